// File: rtl/memory_map_io_pkg.sv
// Shared definitions for the memory_map_io data-memory map: I/O page offsets and region encoding.
package memory_map_io_pkg;

  localparam logic [2:0] IO_KBD     = 3'd0;
  localparam logic [2:0] IO_KQ_DATA = 3'd1;
  localparam logic [2:0] IO_KQ_STAT = 3'd2;
  localparam logic [2:0] IO_TIMER   = 3'd3;

  typedef enum logic [1:0] {
    RegRam,
    RegScreen,
    RegIo,
    RegNone
  } region_e;

endpackage

// File: rtl/memory_map_io_kb_queue.sv
// Circular keyboard FIFO with a sticky overflow flag; pops on empty are ignored.
module memory_map_io_kb_queue #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 8,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic              i_clr_ovf,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_head,
  output logic [CNT_W-1:0]  o_count,
  output logic              o_ovf
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;
  logic              r_ovf;

  logic w_empty;
  logic w_full;
  logic w_do_pop;
  logic w_do_push;
  logic w_drop;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign w_do_pop  = i_pop & ~w_empty;
  // A pop frees the slot this cycle, so a push into a full queue still lands.
  assign w_do_push = i_push & (~w_full | w_do_pop);
  assign w_drop    = i_push & w_full & ~w_do_pop;

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_tail] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_do_push) begin
        r_tail <= r_tail + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_head <= r_head + PTR_W'(1);
      end
      if (w_do_push && !w_do_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (w_do_pop && !w_do_push) begin
        r_count <= r_count - CNT_W'(1);
      end
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (i_clr_ovf) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign o_head  = w_empty ? '0 : r_mem[r_head];
  assign o_count = r_count;
  assign o_ovf   = r_ovf;

endmodule

// File: rtl/memory_map_io.sv
// Data-memory map: RAM, screen and an I/O page with keyboard word, key queue, status and timer.
module memory_map_io
  import memory_map_io_pkg::*;
#(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned RAM_AW   = 14,
  parameter int unsigned SCR_AW   = 13,
  parameter int unsigned KQ_DEPTH = 8,
  localparam int unsigned ADDR_W  = RAM_AW + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              read,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] in,
  input  logic [DATA_W-1:0] kbIn,
  output logic [DATA_W-1:0] out
);

  localparam int unsigned KQ_CNT_W = $clog2(KQ_DEPTH) + 1;

  logic [DATA_W-1:0] r_ram [2**RAM_AW];
  logic [DATA_W-1:0] r_scr [2**SCR_AW];
  logic [DATA_W-1:0] r_kb_prev;
  logic [DATA_W-1:0] r_timer;

  region_e             w_region;
  logic [2:0]          w_io_off;
  logic                w_sel_kq_data;
  logic                w_sel_kq_stat;
  logic                w_sel_timer;
  logic                w_push;
  logic                w_pop;
  logic                w_clr_ovf;
  logic [DATA_W-1:0]   w_kq_head;
  logic [KQ_CNT_W-1:0] w_kq_count;
  logic                w_kq_ovf;
  logic [DATA_W-1:0]   w_stat;
  logic [DATA_W-1:0]   w_out;

  // I/O page needs every address bit between the region bits and the offset to be zero.
  always_comb begin
    w_region = RegNone;
    if (!address[ADDR_W-1]) begin
      w_region = RegRam;
    end else if (!address[ADDR_W-2]) begin
      w_region = RegScreen;
    end else if (address[ADDR_W-3:3] == '0) begin
      w_region = RegIo;
    end
  end

  assign w_io_off      = address[2:0];
  assign w_sel_kq_data = (w_region == RegIo) && (w_io_off == IO_KQ_DATA);
  assign w_sel_kq_stat = (w_region == RegIo) && (w_io_off == IO_KQ_STAT);
  assign w_sel_timer   = (w_region == RegIo) && (w_io_off == IO_TIMER);

  assign w_push    = (kbIn != r_kb_prev) && (kbIn != '0);
  assign w_pop     = read & w_sel_kq_data;
  assign w_clr_ovf = load & w_sel_kq_stat;

  always_ff @(posedge clk) begin
    if (load && (w_region == RegRam)) begin
      r_ram[address[RAM_AW-1:0]] <= in;
    end
  end

  always_ff @(posedge clk) begin
    if (load && (w_region == RegScreen)) begin
      r_scr[address[SCR_AW-1:0]] <= in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_kb_prev <= '0;
      r_timer   <= '0;
    end else begin
      r_kb_prev <= kbIn;
      r_timer   <= (load && w_sel_timer) ? in : r_timer + DATA_W'(1);
    end
  end

  memory_map_io_kb_queue #(
    .DATA_W (DATA_W),
    .DEPTH  (KQ_DEPTH)
  ) u_kb_queue (
    .clk       (clk),
    .reset     (reset),
    .i_push    (w_push),
    .i_pop     (w_pop),
    .i_clr_ovf (w_clr_ovf),
    .i_data    (kbIn),
    .o_head    (w_kq_head),
    .o_count   (w_kq_count),
    .o_ovf     (w_kq_ovf)
  );

  always_comb begin
    w_stat     = '0;
    w_stat[15] = w_kq_ovf;
    w_stat[7:0] = 8'(w_kq_count);
  end

  always_comb begin
    w_out = '0;
    unique case (w_region)
      RegRam:    w_out = r_ram[address[RAM_AW-1:0]];
      RegScreen: w_out = r_scr[address[SCR_AW-1:0]];
      RegIo: begin
        case (w_io_off)
          IO_KBD:     w_out = kbIn;
          IO_KQ_DATA: w_out = w_kq_head;
          IO_KQ_STAT: w_out = w_stat;
          IO_TIMER:   w_out = r_timer;
          default:    w_out = '0;
        endcase
      end
      default:   w_out = '0;
    endcase
  end

  assign out = w_out;

endmodule

// File: tb/tb_memory_map_io.sv
// Directed bench for memory_map_io: decode, key capture, queue overflow, timer and reset.
module tb_memory_map_io;

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic        read;
  logic [14:0] address;
  logic [15:0] in_d;
  logic [15:0] kb;
  logic [15:0] out_d;

  int tests = 0;
  int fails = 0;

  memory_map_io dut (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .read    (read),
    .address (address),
    .in      (in_d),
    .kbIn    (kb),
    .out     (out_d)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic peek(input logic [14:0] a);
    address = a;
    #1;
  endtask

  task automatic wr(input logic [14:0] a, input logic [15:0] d);
    address = a;
    in_d    = d;
    load    = 1'b1;
    cyc();
    load    = 1'b0;
  endtask

  // Value is sampled before the edge on which the pop takes effect.
  task automatic pop(output logic [15:0] v);
    address = 15'h6001;
    read    = 1'b1;
    #1;
    v = out_d;
    cyc();
    read = 1'b0;
  endtask

  task automatic test_reset();
    cyc();
    cyc();
    peek(15'h6002);
    tests++;
    if (out_d !== 16'h0000) begin
      fails++;
      $display("FAIL reset_stat: got %h expected %h", out_d, 16'h0000);
    end
    peek(15'h6003);
    tests++;
    if (out_d !== 16'h0000) begin
      fails++;
      $display("FAIL reset_timer: got %h expected %h", out_d, 16'h0000);
    end
    peek(15'h6001);
    tests++;
    if (out_d !== 16'h0000) begin
      fails++;
      $display("FAIL reset_kq_data: got %h expected %h", out_d, 16'h0000);
    end
    kb = 16'h0077;
    peek(15'h6000);
    tests++;
    if (out_d !== 16'h0077) begin
      fails++;
      $display("FAIL reset_kbd: got %h expected %h", out_d, 16'h0077);
    end
    kb    = 16'h0000;
    reset = 1'b0;
    cyc();
    peek(15'h6003);
    tests++;
    if (out_d !== 16'h0001) begin
      fails++;
      $display("FAIL timer_first_tick: got %h expected %h", out_d, 16'h0001);
    end
  endtask

  task automatic test_decode();
    wr(15'h0005, 16'h1234);
    wr(15'h4005, 16'hBEEF);
    peek(15'h0005);
    tests++;
    if (out_d !== 16'h1234) begin
      fails++;
      $display("FAIL ram5: got %h expected %h", out_d, 16'h1234);
    end
    peek(15'h4005);
    tests++;
    if (out_d !== 16'hBEEF) begin
      fails++;
      $display("FAIL scr5: got %h expected %h", out_d, 16'hBEEF);
    end
    wr(15'h6005, 16'hAAAA);
    peek(15'h6005);
    tests++;
    if (out_d !== 16'h0000) begin
      fails++;
      $display("FAIL reserved_6005: got %h expected %h", out_d, 16'h0000);
    end
    peek(15'h0005);
    tests++;
    if (out_d !== 16'h1234) begin
      fails++;
      $display("FAIL ram5_after_reserved: got %h expected %h", out_d, 16'h1234);
    end
    peek(15'h4005);
    tests++;
    if (out_d !== 16'hBEEF) begin
      fails++;
      $display("FAIL scr5_after_reserved: got %h expected %h", out_d, 16'hBEEF);
    end
    cyc();
    peek(15'h6008);
    tests++;
    if (out_d !== 16'h0000) begin
      fails++;
      $display("FAIL reserved_upper: got %h expected %h", out_d, 16'h0000);
    end
  endtask

  task automatic test_key_edge();
    logic [15:0] v;
    kb = 16'h0041;
    peek(15'h6000);
    tests++;
    if (out_d !== 16'h0041) begin
      fails++;
      $display("FAIL kbd_level: got %h expected %h", out_d, 16'h0041);
    end
    repeat (5) cyc();
    kb = 16'h0000;
    cyc();
    kb = 16'h0042;
    peek(15'h6000);
    tests++;
    if (out_d !== 16'h0042) begin
      fails++;
      $display("FAIL kbd_level2: got %h expected %h", out_d, 16'h0042);
    end
    cyc();
    kb = 16'h0000;
    cyc();
    peek(15'h6002);
    tests++;
    if (out_d !== 16'h0002) begin
      fails++;
      $display("FAIL key_count: got %h expected %h", out_d, 16'h0002);
    end
    pop(v);
    tests++;
    if (v !== 16'h0041) begin
      fails++;
      $display("FAIL key_pop1: got %h expected %h", v, 16'h0041);
    end
    pop(v);
    tests++;
    if (v !== 16'h0042) begin
      fails++;
      $display("FAIL key_pop2: got %h expected %h", v, 16'h0042);
    end
    pop(v);
    tests++;
    if (v !== 16'h0000) begin
      fails++;
      $display("FAIL key_pop_empty: got %h expected %h", v, 16'h0000);
    end
    peek(15'h6002);
    tests++;
    if (out_d !== 16'h0000) begin
      fails++;
      $display("FAIL key_count_empty: got %h expected %h", out_d, 16'h0000);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 9; i++) begin
      kb = 16'(16'h0100 + i);
      cyc();
    end
    kb = 16'h0000;
    cyc();
    peek(15'h6002);
    tests++;
    if (out_d !== 16'h8008) begin
      fails++;
      $display("FAIL ovf_stat: got %h expected %h", out_d, 16'h8008);
    end
    peek(15'h6001);
    tests++;
    if (out_d !== 16'h0100) begin
      fails++;
      $display("FAIL ovf_head: got %h expected %h", out_d, 16'h0100);
    end
    wr(15'h6002, 16'hFFFF);
    peek(15'h6002);
    tests++;
    if (out_d !== 16'h0008) begin
      fails++;
      $display("FAIL ovf_clear: got %h expected %h", out_d, 16'h0008);
    end
  endtask

  task automatic test_full_simultaneous();
    logic [15:0] v;
    logic [15:0] exp_v;
    kb      = 16'h0200;
    address = 15'h6001;
    read    = 1'b1;
    #1;
    tests++;
    if (out_d !== 16'h0100) begin
      fails++;
      $display("FAIL full_pop_oldest: got %h expected %h", out_d, 16'h0100);
    end
    cyc();
    read = 1'b0;
    kb   = 16'h0000;
    peek(15'h6002);
    tests++;
    if (out_d !== 16'h0008) begin
      fails++;
      $display("FAIL full_stat: got %h expected %h", out_d, 16'h0008);
    end
    for (int i = 0; i < 8; i++) begin
      exp_v = (i < 7) ? 16'(16'h0101 + i) : 16'h0200;
      pop(v);
      tests++;
      if (v !== exp_v) begin
        fails++;
        $display("FAIL full_drain[%0d]: got %h expected %h", i, v, exp_v);
      end
    end
    peek(15'h6002);
    tests++;
    if (out_d !== 16'h0000) begin
      fails++;
      $display("FAIL full_drained_stat: got %h expected %h", out_d, 16'h0000);
    end
  endtask

  task automatic test_timer();
    wr(15'h6003, 16'hFFFE);
    peek(15'h6003);
    tests++;
    if (out_d !== 16'hFFFE) begin
      fails++;
      $display("FAIL timer_load: got %h expected %h", out_d, 16'hFFFE);
    end
    cyc();
    peek(15'h6003);
    tests++;
    if (out_d !== 16'hFFFF) begin
      fails++;
      $display("FAIL timer_inc: got %h expected %h", out_d, 16'hFFFF);
    end
    cyc();
    peek(15'h6003);
    tests++;
    if (out_d !== 16'h0000) begin
      fails++;
      $display("FAIL timer_wrap: got %h expected %h", out_d, 16'h0000);
    end
    wr(15'h6003, 16'h1234);
    peek(15'h6003);
    tests++;
    if (out_d !== 16'h1234) begin
      fails++;
      $display("FAIL timer_load_wins: got %h expected %h", out_d, 16'h1234);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] v;
    for (int i = 0; i < 9; i++) begin
      kb = 16'(16'h0300 + i);
      cyc();
    end
    kb = 16'h0000;
    cyc();
    for (int i = 0; i < 5; i++) begin
      pop(v);
    end
    peek(15'h6002);
    tests++;
    if (out_d !== 16'h8003) begin
      fails++;
      $display("FAIL pre_reset_stat: got %h expected %h", out_d, 16'h8003);
    end
    wr(15'h6003, 16'h0123);
    peek(15'h6003);
    tests++;
    if (out_d !== 16'h0123) begin
      fails++;
      $display("FAIL pre_reset_timer: got %h expected %h", out_d, 16'h0123);
    end
    kb    = 16'h0055;
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    peek(15'h6002);
    tests++;
    if (out_d !== 16'h0000) begin
      fails++;
      $display("FAIL post_reset_stat: got %h expected %h", out_d, 16'h0000);
    end
    peek(15'h6001);
    tests++;
    if (out_d !== 16'h0000) begin
      fails++;
      $display("FAIL post_reset_kq_data: got %h expected %h", out_d, 16'h0000);
    end
    peek(15'h6003);
    tests++;
    if (out_d !== 16'h0000) begin
      fails++;
      $display("FAIL post_reset_timer: got %h expected %h", out_d, 16'h0000);
    end
    peek(15'h0005);
    tests++;
    if (out_d !== 16'h1234) begin
      fails++;
      $display("FAIL post_reset_ram: got %h expected %h", out_d, 16'h1234);
    end
    cyc();
    peek(15'h6002);
    tests++;
    if (out_d !== 16'h0001) begin
      fails++;
      $display("FAIL held_key_count: got %h expected %h", out_d, 16'h0001);
    end
    peek(15'h6001);
    tests++;
    if (out_d !== 16'h0055) begin
      fails++;
      $display("FAIL held_key_head: got %h expected %h", out_d, 16'h0055);
    end
    kb = 16'h0000;
  endtask

  initial begin
    reset   = 1'b1;
    load    = 1'b0;
    read    = 1'b0;
    address = '0;
    in_d    = '0;
    kb      = '0;
    test_reset();
    test_decode();
    test_key_edge();
    test_overflow();
    test_full_simultaneous();
    test_timer();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
